gate_tt_checker: RTL and testbench

Hardware truth-table checker for small combinational gates. It drives every input combination to a gate under test and samples the gate output after a settle time. It compares each sample against an expected truth table, then reports per-row results, a mismatch count and pass/fail. It is the on-chip counterpart of our gate benches and lets lab boards self-test and_gate, or_gate and similar gates without a simulator.

---
 rtl/gate_tt_checker_pkg.sv | 18 +
 rtl/tt_settle_timer.sv | 38 +++
 rtl/gate_tt_checker.sv | 124 ++++++++++++
 tb/tb_gate_tt_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_checker_pkg.sv
// Shared types and truth-table constants for the gate truth-table checker.
package gate_tt_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Expected outputs for 2-input gates; bit r is Y when stim == r.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle timer: a down-counter loaded on clear, expiring at zero.
// expire is high on the (SETTLE+1)th cycle after clear.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);

    localparam logic [3:0] LOAD = 4'(SETTLE);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Reload on clear, otherwise count down and park at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table checker: sweeps every input combination of a small gate, holds
// each row SETTLE+1 cycles, samples y_in and compares it with EXPECTED.
//
// state  | meaning
// S_IDLE | waiting for start; results of the last sweep held stable
// S_HOLD | driving stim = row, sampling y_in when the settle timer expires
// S_DONE | one-cycle done pulse, then back to S_IDLE
module gate_tt_checker
    import gate_tt_checker_pkg::*;
#(
    parameter int                     N_IN     = 2,
    parameter int                     SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = TT_AND
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        stim,
    input  logic                   y_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [(1<<N_IN)-1:0]   result_vec,
    output logic [(1<<N_IN)-1:0]   fail_mask
);

    localparam int              ROWS     = 1 << N_IN;
    localparam int              EW       = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_ROW = {N_IN{1'b1}};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [N_IN:0]     err_q, err_d;
    logic [ROWS-1:0]   result_q, result_d;
    logic [ROWS-1:0]   fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              timer_clear;
    logic              expire;
    logic              mis;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .expire (expire)
    );

    assign mis = y_in ^ EXPECTED[row_q];

    // Next-state logic: sweep sequencing, per-row sampling and scoring.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        err_d       = err_q;
        result_d    = result_q;
        fail_d      = fail_q;
        pass_d      = pass_q;
        timer_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_HOLD;
                    row_d       = '0;
                    err_d       = '0;
                    result_d    = '0;
                    fail_d      = '0;
                    pass_d      = 1'b0;
                    timer_clear = 1'b1;
                end
            end
            S_HOLD: begin
                if (expire) begin
                    result_d[row_q] = y_in;
                    fail_d[row_q]   = mis;
                    err_d           = err_q + EW'(mis);
                    timer_clear     = 1'b1;
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        row_d = row_q + N_IN'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            err_q    <= '0;
            result_q <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            err_q    <= err_d;
            result_q <= result_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
        end
    end

    assign busy       = (state_q == S_HOLD);
    assign done       = (state_q == S_DONE);
    assign stim       = busy ? row_q : '0;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign result_vec = result_q;
    assign fail_mask  = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker with several parameterisations.
module tb_gate_tt_checker;
    import gate_tt_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_o, start_r;
    logic [1:0] gate_sel;

    logic [1:0] stim_a, stim_o, stim_r0, stim_r1;
    logic       y_a, y_o, y_r0, y_r1;
    logic       busy_a, busy_o, busy_r0, busy_r1;
    logic       done_a, done_o, done_r0, done_r1;
    logic       pass_a, pass_o, pass_r0, pass_r1;
    logic [2:0] err_a, err_o, err_r0, err_r1;
    logic [3:0] res_a, res_o, res_r0, res_r1;
    logic [3:0] fm_a, fm_o, fm_r0, fm_r1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Selectable gate under test for the main instance.
    always_comb begin
        case (gate_sel)
            2'd0:    y_a = &stim_a;
            2'd1:    y_a = 1'b0;
            2'd2:    y_a = |stim_a;
            default: y_a = 1'b1;
        endcase
    end

    assign y_o = |stim_o;

    // AND gates with a registered output (one cycle late).
    always @(posedge clk) begin
        y_r0 <= &stim_r0;
        y_r1 <= &stim_r1;
    end

    gate_tt_checker #(.N_IN(2), .SETTLE(2), .EXPECTED(TT_AND)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .y_in(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .result_vec(res_a), .fail_mask(fm_a));

    gate_tt_checker #(.N_IN(2), .SETTLE(2), .EXPECTED(TT_OR)) u_o (
        .clk(clk), .rst(rst), .start(start_o), .stim(stim_o), .y_in(y_o),
        .busy(busy_o), .done(done_o), .pass(pass_o), .err_count(err_o),
        .result_vec(res_o), .fail_mask(fm_o));

    gate_tt_checker #(.N_IN(2), .SETTLE(0), .EXPECTED(TT_AND)) u_r0 (
        .clk(clk), .rst(rst), .start(start_r), .stim(stim_r0), .y_in(y_r0),
        .busy(busy_r0), .done(done_r0), .pass(pass_r0), .err_count(err_r0),
        .result_vec(res_r0), .fail_mask(fm_r0));

    gate_tt_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(TT_AND)) u_r1 (
        .clk(clk), .rst(rst), .start(start_r), .stim(stim_r1), .y_in(y_r1),
        .busy(busy_r1), .done(done_r1), .pass(pass_r1), .err_count(err_r1),
        .result_vec(res_r1), .fail_mask(fm_r1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on u_a from IDLE; returns positioned in the DONE cycle (13).
    task automatic sweep_a(input string tag, input logic [3:0] e_res, input logic [3:0] e_fm,
                           input logic [2:0] e_err, input logic e_pass, input bit mid);
        start_a = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            start_a = (mid && (c == 4 || c == 9)) ? 1'b1 : 1'b0;
            chk({tag, "_stim"}, 32'(stim_a), 32'((c - 1) / 3));
            chk({tag, "_busy"}, 32'(busy_a), 32'd1);
            chk({tag, "_done_early"}, 32'(done_a), 32'd0);
            step();
        end
        start_a = 1'b0;
        chk({tag, "_done"}, 32'(done_a), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_a), 32'd0);
        chk({tag, "_stim_end"}, 32'(stim_a), 32'd0);
        chk({tag, "_result"}, 32'(res_a), 32'(e_res));
        chk({tag, "_fail_mask"}, 32'(fm_a), 32'(e_fm));
        chk({tag, "_err"}, 32'(err_a), 32'(e_err));
        chk({tag, "_pass"}, 32'(pass_a), 32'(e_pass));
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_o  = 1'b0;
        start_r  = 1'b0;
        gate_sel = 2'd0;
        step();
        step();
        chk("rst_stim", 32'(stim_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_result", 32'(res_a), 32'd0);
        chk("rst_fail_mask", 32'(fm_a), 32'd0);
        rst = 1'b0;
        step();

        // and_gate against the AND table
        gate_sel = 2'd0;
        sweep_a("t1", 4'b1000, 4'b0000, 3'd0, 1'b1, 1'b0);
        step();
        chk("t1_done_pulse", 32'(done_a), 32'd0);
        chk("t1_hold_result", 32'(res_a), 32'h8);

        // output stuck at 0
        gate_sel = 2'd1;
        sweep_a("t2", 4'b0000, 4'b1000, 3'd1, 1'b0, 1'b0);
        step();

        // or_gate against the AND table
        gate_sel = 2'd2;
        sweep_a("t3", 4'b1110, 4'b0110, 3'd2, 1'b0, 1'b0);
        step();

        // or_gate against the OR table
        start_o = 1'b1;
        step();
        start_o = 1'b0;
        chk("t3o_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 12; i++) step();
        chk("t3o_done", 32'(done_o), 32'd1);
        chk("t3o_pass", 32'(pass_o), 32'd1);
        chk("t3o_result", 32'(res_o), 32'he);
        chk("t3o_err", 32'(err_o), 32'd0);

        // start pulses mid-sweep are ignored, post-done start accepted
        gate_sel = 2'd0;
        sweep_a("t4", 4'b1000, 4'b0000, 3'd0, 1'b1, 1'b1);
        step();
        chk("t4_idle_busy", 32'(busy_a), 32'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t4_restart_busy", 32'(busy_a), 32'd1);
        chk("t4_restart_stim", 32'(stim_a), 32'd0);
        chk("t4_clr_result", 32'(res_a), 32'd0);
        chk("t4_clr_pass", 32'(pass_a), 32'd0);
        chk("t4_clr_err", 32'(err_a), 32'd0);
        for (int i = 0; i < 12; i++) step();
        chk("t4_done2", 32'(done_a), 32'd1);
        chk("t4_pass2", 32'(pass_a), 32'd1);
        step();

        // reset mid-sweep while stim = 2, output stuck at 1
        gate_sel = 2'd3;
        start_a  = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t5_stim_pre", 32'(stim_a), 32'd2);
        chk("t5_partial_fm", 32'(fm_a), 32'h3);
        chk("t5_partial_err", 32'(err_a), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_stim", 32'(stim_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_result", 32'(res_a), 32'd0);
        chk("t5_fail_mask", 32'(fm_a), 32'd0);
        chk("t5_err", 32'(err_a), 32'd0);
        step();
        gate_sel = 2'd0;
        sweep_a("t5b", 4'b1000, 4'b0000, 3'd0, 1'b1, 1'b0);
        step();

        // registered DUT: SETTLE=0 samples stale data, SETTLE=1 passes
        start_r = 1'b1;
        step();
        start_r = 1'b0;
        chk("t6_busy0", 32'(busy_r0), 32'd1);
        chk("t6_busy1", 32'(busy_r1), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t6_done0", 32'(done_r0), 32'd1);
        chk("t6_result0", 32'(res_r0), 32'd0);
        chk("t6_fail_mask0", 32'(fm_r0), 32'h8);
        chk("t6_err0", 32'(err_r0), 32'd1);
        chk("t6_pass0", 32'(pass_r0), 32'd0);
        chk("t6_busy1_mid", 32'(busy_r1), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t6_done1", 32'(done_r1), 32'd1);
        chk("t6_result1", 32'(res_r1), 32'h8);
        chk("t6_fail_mask1", 32'(fm_r1), 32'd0);
        chk("t6_pass1", 32'(pass_r1), 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
